// File: rtl/pe_sequencer.sv
// Frame-pass controller for an array of background-removal PEs: sum phase, reduction
// to the expected background colour, then background-replace phase, with wait timeouts.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for Go after reset
// SUM_START | Start_Sum pulse, clear accumulators and wait counter
// SUM_WAIT  | waiting for every PE sum-done flag (or timeout)
// SUM_ACK   | Ack pulse, PE index reset
// ACCUM     | add one PE's r/g/b sums per cycle
// DIVIDE    | expected colour = total >> LOG2_PIX, saturated
// BG_START  | Start_BgRemoval pulse, clear wait counter
// BG_WAIT   | waiting for every PE bg-done flag (or timeout)
// BG_ACK    | Ack pulse
// DONE      | pass complete, hold until Go
// ERROR     | a wait timed out, hold until Go
module pe_sequencer #(
    parameter int NUM_PE   = 4,
    parameter int SUM_W    = 16,
    parameter int LOG2_PIX = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Go,
    input  logic                    Use_Fixed_Exp,
    input  logic [7:0]              fixed_r,
    input  logic [7:0]              fixed_g,
    input  logic [7:0]              fixed_b,
    input  logic [NUM_PE-1:0]       Qsd_all,
    input  logic [NUM_PE-1:0]       Qbgd_all,
    input  logic [NUM_PE*SUM_W-1:0] sum_r_in,
    input  logic [NUM_PE*SUM_W-1:0] sum_g_in,
    input  logic [NUM_PE*SUM_W-1:0] sum_b_in,
    output logic                    Start_Sum,
    output logic                    Start_BgRemoval,
    output logic                    Ack,
    output logic [7:0]              red_exp,
    output logic [7:0]              green_exp,
    output logic [7:0]              blue_exp,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic [10:0]             State
);

    localparam int ACC_W = SUM_W + 8;
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PE - 1);

    // One-hot encoding so each state bit doubles as a registered output.
    typedef enum logic [10:0] {
        S_IDLE      = 11'b000_0000_0001,
        S_SUM_START = 11'b000_0000_0010,
        S_SUM_WAIT  = 11'b000_0000_0100,
        S_SUM_ACK   = 11'b000_0000_1000,
        S_ACCUM     = 11'b000_0001_0000,
        S_DIVIDE    = 11'b000_0010_0000,
        S_BG_START  = 11'b000_0100_0000,
        S_BG_WAIT   = 11'b000_1000_0000,
        S_BG_ACK    = 11'b001_0000_0000,
        S_DONE      = 11'b010_0000_0000,
        S_ERROR     = 11'b100_0000_0000
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic [7:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               busy_q, busy_d, ack_q, ack_d;

    function automatic logic [7:0] div_sat(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> LOG2_PIX;
        return (|shifted[ACC_W-1:8]) ? 8'hFF : shifted[7:0];
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Go) begin
                    if (Use_Fixed_Exp) begin
                        state_d = S_BG_START;
                        red_d   = fixed_r;
                        green_d = fixed_g;
                        blue_d  = fixed_b;
                    end else begin
                        state_d = S_SUM_START;
                    end
                end
            end
            S_SUM_START: begin
                acc_r_d = '0;
                acc_g_d = '0;
                acc_b_d = '0;
                cnt_d   = '0;
                state_d = S_SUM_WAIT;
            end
            // All-done takes priority over the timeout on the same cycle.
            S_SUM_WAIT: begin
                if (&Qsd_all)            state_d = S_SUM_ACK;
                else if (cnt_q == CNT_MAX) state_d = S_ERROR;
                else                     cnt_d = cnt_q + 1'b1;
            end
            S_SUM_ACK: begin
                idx_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                acc_r_d = acc_r_q + ACC_W'(sum_r_in[int'(idx_q)*SUM_W +: SUM_W]);
                acc_g_d = acc_g_q + ACC_W'(sum_g_in[int'(idx_q)*SUM_W +: SUM_W]);
                acc_b_d = acc_b_q + ACC_W'(sum_b_in[int'(idx_q)*SUM_W +: SUM_W]);
                if (idx_q == IDX_LAST) state_d = S_DIVIDE;
                else                   idx_d = idx_q + 1'b1;
            end
            S_DIVIDE: begin
                red_d   = div_sat(acc_r_q);
                green_d = div_sat(acc_g_q);
                blue_d  = div_sat(acc_b_q);
                state_d = S_BG_START;
            end
            S_BG_START: begin
                cnt_d   = '0;
                state_d = S_BG_WAIT;
            end
            S_BG_WAIT: begin
                if (&Qbgd_all)           state_d = S_BG_ACK;
                else if (cnt_q == CNT_MAX) state_d = S_ERROR;
                else                     cnt_d = cnt_q + 1'b1;
            end
            S_BG_ACK: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
        ack_d  = (state_d == S_SUM_ACK) || (state_d == S_BG_ACK);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_r_q <= acc_r_d;
            acc_g_q <= acc_g_d;
            acc_b_q <= acc_b_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign State           = state_q;
    assign Start_Sum       = state_q[1];
    assign Start_BgRemoval = state_q[6];
    assign Done            = state_q[9];
    assign Error           = state_q[10];
    assign Ack             = ack_q;
    assign Busy            = busy_q;
    assign red_exp         = red_q;
    assign green_exp       = green_q;
    assign blue_exp        = blue_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: a pass-level model predicts each frame outcome,
// a monitor compares it when the DUT reaches DONE or ERROR.
module tb_pe_sequencer;

    localparam int N   = 4;
    localparam int SW  = 16;
    localparam int LP  = 4;
    localparam int TO  = 8;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            Go = 1'b0;
    logic            Use_Fixed_Exp = 1'b0;
    logic [7:0]      fixed_r = '0, fixed_g = '0, fixed_b = '0;
    logic [N-1:0]    Qsd_all = '0, Qbgd_all = '0;
    logic [N*SW-1:0] sum_r_in = '0, sum_g_in = '0, sum_b_in = '0;
    logic            Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error;
    logic [7:0]      red_exp, green_exp, blue_exp;
    logic [10:0]     State;

    pe_sequencer #(.NUM_PE(N), .SUM_W(SW), .LOG2_PIX(LP), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Use_Fixed_Exp(Use_Fixed_Exp),
        .fixed_r(fixed_r), .fixed_g(fixed_g), .fixed_b(fixed_b),
        .Qsd_all(Qsd_all), .Qbgd_all(Qbgd_all),
        .sum_r_in(sum_r_in), .sum_g_in(sum_g_in), .sum_b_in(sum_b_in),
        .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .Busy(Busy), .Done(Done), .Error(Error), .State(State)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         err;
        logic [7:0] r, g, b;
        int         n_ss, n_sb, n_ack, ack_cyc, end_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ds[N], db[N];
    int         sr[N], sg[N], sbl[N];
    logic [7:0] m_r = 0, m_g = 0, m_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // PE array stand-in: each flag rises ds/db[i] cycles after the wait state begins.
    int rc = 0, s_st = 0, b_st = 0;
    bit s_arm = 0, b_arm = 0;
    initial forever begin
        @(negedge Clk);
        rc++;
        if (!Reset) begin
            s_arm = 0;
            b_arm = 0;
        end else begin
            if (Start_Sum)       begin s_arm = 1; s_st = rc; end
            if (Start_BgRemoval) begin b_arm = 1; b_st = rc; end
            if (Ack || Error)    begin s_arm = 0; b_arm = 0; end
        end
        for (int i = 0; i < N; i++) begin
            Qsd_all[i]  = s_arm && (rc - s_st >= 1 + ds[i]);
            Qbgd_all[i] = b_arm && (rc - b_st >= 1 + db[i]);
        end
    end

    // Monitor: tracks one pass from the first busy cycle to DONE/ERROR.
    bit active = 0;
    int cyc, c_ss, c_sb, c_ack, c_ack_cyc;
    initial forever begin
        @(negedge Clk);
        if (!Reset) begin
            active = 0;
        end else begin
            if (!active && Busy) begin
                active = 1; cyc = 0; c_ss = 0; c_sb = 0; c_ack = 0; c_ack_cyc = 0;
            end
            if (active) begin
                cyc++;
                c_ss  += int'(Start_Sum);
                c_sb  += int'(Start_BgRemoval);
                if (Ack) begin
                    c_ack++;
                    if (c_ack_cyc == 0) c_ack_cyc = cyc;
                end
                if (Done || Error) begin
                    active = 0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pass_end", 32'(State), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("error_flag", 32'(Error), 32'(e.err));
                        chk("done_flag", 32'(Done), 32'(!e.err));
                        chk("red_exp", 32'(red_exp), 32'(e.r));
                        chk("green_exp", 32'(green_exp), 32'(e.g));
                        chk("blue_exp", 32'(blue_exp), 32'(e.b));
                        chk("start_sum_pulses", 32'(c_ss), 32'(e.n_ss));
                        chk("start_bg_pulses", 32'(c_sb), 32'(e.n_sb));
                        chk("ack_pulses", 32'(c_ack), 32'(e.n_ack));
                        chk("first_ack_cycle", 32'(c_ack_cyc), 32'(e.ack_cyc));
                        chk("end_cycle", 32'(cyc), 32'(e.end_cyc));
                    end
                end
            end
        end
    end

    function automatic logic [7:0] sat_avg(input int v[N]);
        int tot = 0;
        for (int i = 0; i < N; i++) tot += v[i];
        tot = tot >> LP;
        return (tot > 255) ? 8'd255 : 8'(tot);
    endfunction

    // Pass-level prediction from the documented phase timing.
    function automatic exp_t predict(input bit fx, input logic [7:0] fr, fg, fb);
        exp_t e;
        int   d_s = 0, d_b = 0, bstart;
        for (int i = 0; i < N; i++) begin
            if (ds[i] > d_s) d_s = ds[i];
            if (db[i] > d_b) d_b = db[i];
        end
        e.err = 0; e.n_ss = 0; e.n_sb = 0; e.n_ack = 0; e.ack_cyc = 0; e.end_cyc = 0;
        bstart = 1;
        if (fx) begin
            m_r = fr; m_g = fg; m_b = fb;
        end else begin
            e.n_ss = 1;
            if (d_s >= TO) begin
                e.err = 1;
                e.end_cyc = 2 + TO;
            end else begin
                e.n_ack = 1;
                e.ack_cyc = 3 + d_s;
                m_r = sat_avg(sr); m_g = sat_avg(sg); m_b = sat_avg(sbl);
                bstart = 5 + d_s + N;
            end
        end
        if (!e.err) begin
            e.n_sb = 1;
            if (d_b >= TO) begin
                e.err = 1;
                e.end_cyc = bstart + 1 + TO;
            end else begin
                e.n_ack++;
                if (e.ack_cyc == 0) e.ack_cyc = bstart + 2 + d_b;
                e.end_cyc = bstart + 3 + d_b;
            end
        end
        e.r = m_r; e.g = m_g; e.b = m_b;
        return e;
    endfunction

    task automatic load_sums();
        for (int i = 0; i < N; i++) begin
            sum_r_in[i*SW +: SW] = SW'(sr[i]);
            sum_g_in[i*SW +: SW] = SW'(sg[i]);
            sum_b_in[i*SW +: SW] = SW'(sbl[i]);
        end
    endtask

    task automatic run_pass(input bit fx, input logic [7:0] fr, fg, fb, input bit go_mid);
        exp_t e;
        int   k;
        load_sums();
        e = predict(fx, fr, fg, fb);
        sb_q.push_back(e);
        @(negedge Clk);
        Go = 1; Use_Fixed_Exp = fx; fixed_r = fr; fixed_g = fg; fixed_b = fb;
        @(posedge Clk); #1;
        chk("start_state", 32'(State), fx ? 32'h40 : 32'h2);
        chk("start_clears_flags", 32'({Done, Error}), 32'd0);
        @(negedge Clk);
        Go = 0;
        Use_Fixed_Exp = 1'($urandom);
        fixed_r = 8'($urandom); fixed_g = 8'($urandom); fixed_b = 8'($urandom);
        k = 1;
        while (!(Done || Error) && k < 400) begin
            Go = go_mid && (k == 3) && (e.end_cyc > 4);
            @(negedge Clk);
            k++;
        end
        Go = 0;
        if (k >= 400) chk("pass_timeout", 32'(k), 32'd0);
        @(negedge Clk);
    endtask

    task automatic set_all(input int dsv, input int dbv, input int r, input int g, input int b);
        for (int i = 0; i < N; i++) begin
            ds[i] = dsv; db[i] = dbv; sr[i] = r; sg[i] = g; sbl[i] = b;
        end
    endtask

    initial begin
        int k;
        set_all(0, 0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        chk("reset_state", 32'(State), 32'h1);
        chk("reset_outputs", 32'({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error}), 32'd0);
        chk("reset_exp", 32'({red_exp, green_exp, blue_exp}), 32'd0);
        Reset = 1;
        @(negedge Clk);
        chk("idle_after_release", 32'(State), 32'h1);

        // Fixed colour, bg flags three cycles after Start_BgRemoval.
        set_all(0, 2, 0, 0, 0);
        run_pass(1, 8'd10, 8'd20, 8'd30, 0);

        // Sum path 400/800/0 per PE.
        set_all(4, 3, 400, 800, 0);
        run_pass(0, 8'd0, 8'd0, 8'd0, 0);

        // Staggered sum-done; last bit lands on the final allowed wait cycle.
        set_all(0, 1, 100, 200, 300);
        ds[0] = 1; ds[1] = 2; ds[2] = 4; ds[3] = 7;
        run_pass(0, 8'd0, 8'd0, 8'd0, 1);

        // Saturation.
        set_all(2, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_pass(0, 8'd0, 8'd0, 8'd0, 0);

        // Sum timeout with PE0 never done, then restart from ERROR.
        set_all(0, 0, 50, 60, 70);
        ds[0] = 1000;
        run_pass(0, 8'd0, 8'd0, 8'd0, 0);
        set_all(1, 1, 50, 60, 70);
        run_pass(0, 8'd0, 8'd0, 8'd0, 0);

        // Bg timeout on the fixed path, done exactly at the last wait cycle.
        set_all(0, 8, 0, 0, 0);
        run_pass(1, 8'd7, 8'd8, 8'd9, 0);
        set_all(0, 7, 0, 0, 0);
        run_pass(1, 8'd1, 8'd2, 8'd3, 0);

        // Reset during ACCUM, then a clean pass.
        set_all(2, 0, 1000, 2000, 3000);
        load_sums();
        @(negedge Clk);
        Go = 1; Use_Fixed_Exp = 0;
        @(negedge Clk);
        Go = 0;
        k = 0;
        while (!State[4] && k < 100) begin
            @(negedge Clk);
            k++;
        end
        chk("reach_accum", 32'(State[4]), 32'd1);
        Reset = 0;
        #1;
        chk("midpass_reset_state", 32'(State), 32'h1);
        chk("midpass_reset_outputs",
            32'({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error}), 32'd0);
        @(posedge Clk); #1;
        chk("midpass_reset_exp", 32'({red_exp, green_exp, blue_exp}), 32'd0);
        @(negedge Clk);
        Reset = 1;
        m_r = 0; m_g = 0; m_b = 0;
        set_all(1, 1, 320, 640, 960);
        run_pass(0, 8'd0, 8'd0, 8'd0, 0);

        // Randomized passes.
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < N; i++) begin
                ds[i] = ($urandom_range(3) != 0) ? int'($urandom_range(TO - 1)) : int'($urandom_range(TO + 2));
                db[i] = ($urandom_range(3) != 0) ? int'($urandom_range(TO - 1)) : int'($urandom_range(TO + 2));
                if ($urandom_range(1) != 0) begin
                    sr[i] = int'($urandom_range(600)); sg[i] = int'($urandom_range(600));
                    sbl[i] = int'($urandom_range(600));
                end else begin
                    sr[i] = int'($urandom_range(16'hFFFF)); sg[i] = int'($urandom_range(16'hFFFF));
                    sbl[i] = int'($urandom_range(16'hFFFF));
                end
            end
            run_pass(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Controller that sequences an array of `NUM_PE` background-removal processing elements through one full frame pass. The pass has two phases: a sum phase, then reduction of the per-PE colour sums into the expected-background RGB, then a background-replace phase. It drives the shared `Start_Sum`, `Start_BgRemoval`, `Ack`, `red_exp`, `green_exp` and `blue_exp` nets of all PEs. It also gathers their done flags and reports frame completion or timeout to the host.

## Interface
- `NUM_PE`, 4, number of processing elements driven (≥1)
- `SUM_W`, 16, width of each PE's per-channel sum output
- `LOG2_PIX`, 4, log2 of total pixels across all PEs; expected colour = total sum >> `LOG2_PIX`
- `TIMEOUT`, 1024, maximum cycles spent in either wait state before error

- `Clk`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Go`  in  1  start a frame pass; sampled in IDLE, DONE, ERROR only
- `Use_Fixed_Exp`  in  1  sampled with `Go`; 1 = skip sum phase, use `fixed_r/g/b`
- `fixed_r`, `fixed_g`, `fixed_b`  in  8 each  host-supplied expected colour
- `Qsd_all`  in  `NUM_PE`  per-PE sum-done flags
- `Qbgd_all`  in  `NUM_PE`  per-PE bg-done flags
- `sum_r_in`, `sum_g_in`, `sum_b_in`  in  `NUM_PE*SUM_W` each  flattened per-PE sums, PE i at bits [i*SUM_W +: SUM_W]
- `Start_Sum`  out  1  one-cycle pulse to all PEs
- `Start_BgRemoval`  out  1  one-cycle pulse to all PEs
- `Ack`  out  1  one-cycle pulse to all PEs
- `red_exp`, `green_exp`, `blue_exp`  out  8 each  registered expected colour
- `Busy`  out  1  high in every state except IDLE, DONE, ERROR
- `Done`  out  1  high in DONE
- `Error`  out  1  high in ERROR
- `State`  out  11  one-hot state vector, bit order as listed below (IDLE = bit 0)

## Operation
- States: IDLE, SUM_START, SUM_WAIT, SUM_ACK, ACCUM, DIVIDE, BG_START, BG_WAIT, BG_ACK, DONE, ERROR.
- **Start:** `Go`=1 in IDLE/DONE/ERROR clears `Done`/`Error`.
  - Next state is SUM_START, or BG_START when `Use_Fixed_Exp`=1.
  - When `Use_Fixed_Exp`=1, `fixed_*` is loaded into `*_exp` in the same edge.
  - `Go` is ignored in all other states.
- **SUM_START:** `Start_Sum`=1; clear the three accumulators and the wait counter. Go to SUM_WAIT.
- **SUM_WAIT:** when `&Qsd_all` goes to SUM_ACK. Otherwise, when the wait counter reaches `TIMEOUT-1`, go to ERROR. Otherwise increment the counter.
- **SUM_ACK:** `Ack`=1; PE index ← 0. Go to ACCUM.
- **ACCUM:** each cycle add slice [idx] of each `sum_*_in` into a (`SUM_W`+8)-bit accumulator, then idx++. After idx = `NUM_PE-1`, go to DIVIDE. Takes exactly `NUM_PE` cycles.
- **DIVIDE:** `*_exp` ← acc >> `LOG2_PIX`, saturated to 255 if the result exceeds 8 bits. Go to BG_START.
- **BG_START:** `Start_BgRemoval`=1; clear the wait counter. Go to BG_WAIT.
- **BG_WAIT:** same rule as SUM_WAIT, using `&Qbgd_all`.
- **BG_ACK:** `Ack`=1. Go to DONE.
- **DONE, ERROR:** hold until the next `Go`. `*_exp` keeps its last value.
- **Reset (any time, including mid-pass):**
  - state → IDLE;
  - all pulses, `Busy`, `Done`, `Error` → 0;
  - `*_exp`, accumulators, counters → 0;
  - `State` = 11'b1.
  - No `Ack` is issued to the PEs; the PEs must be reset alongside.
- A done flag set in the same cycle the timeout is reached wins: go to the ACK state, not ERROR.

## Timing
- All outputs are registered, decoded from the current state; pulses are exactly one cycle wide.
- Fixed-exp path: `Go` sampled at edge 0 → `Start_BgRemoval` high in cycle 1.
  - BG_WAIT from cycle 2; all `Qbgd` seen in cycle k → `Ack` in cycle k+1 → `Done` from cycle k+2.
- Sum path: `Start_Sum` in cycle 1, SUM_WAIT from cycle 2; all `Qsd` seen in cycle k.
  - `Ack` in cycle k+1, then ACCUM in cycles k+2 .. k+1+`NUM_PE`.
  - DIVIDE in cycle k+2+`NUM_PE`; `*_exp` valid from cycle k+3+`NUM_PE`, which is also the `Start_BgRemoval` cycle.
- Timeout: ERROR entered `TIMEOUT` cycles after entering a wait state with no all-done.
- `*_exp` is stable throughout BG_START..DONE.

## Test plan
- Reset low mid-ACCUM, `NUM_PE`=4 → next cycle `State`=11'b1, all outputs 0; release reset then `Go` → clean new pass.
- `Use_Fixed_Exp`=1, `fixed`=(10,20,30), `Qbgd_all`=4'hF three cycles after `Start_BgRemoval`:
  - `Start_Sum` never pulses;
  - exactly one `Ack` pulse;
  - `Done`=1;
  - `*_exp`=(10,20,30).
- Sum path, each PE sum r=400, g=800, b=0, `LOG2_PIX`=4, PEs finish after 5 cycles:
  - `*_exp`=(100,200,0);
  - two `Ack` pulses;
  - `Done`=1 after the bg phase.
- Staggered done (`Qsd_all` bits rise in cycles 3,4,6,9) → `Ack` only in the cycle after bit 3 rises.
- All PE sums 16'hFFFF → `*_exp`=(255,255,255) via saturation.
- `TIMEOUT`=8 with `Qsd_all`=4'hE held:
  - `Error`=1 eight cycles after SUM_WAIT entry;
  - no `Ack`;
  - `Go` in ERROR clears `Error` and restarts at SUM_START.
